// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared definitions for the execute stage.
//   - ALU opcode encodings (ALU_ADD .. ALU_MUL)
//   - multiplier sequencing state type (IDLE / MUL / DONE)
//   - registered control bundle and its bubble value
//   - forwarding source select and its priority function
package ex_stage_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } ex_state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_read;
        logic reg_store;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_WB    = 2'd2
    } fwd_sel_t;

    // EX/MEM wins over MEM/WB. A load in EX/MEM has no data yet, so it is
    // never a source; load-use stalls are handled before this stage.
    function automatic fwd_sel_t fwd_select(
        input logic ex_write,
        input logic ex_load,
        input logic ex_match,
        input logic ex_rd_zero,
        input logic wb_write,
        input logic wb_match,
        input logic wb_rd_zero
    );
        fwd_sel_t sel;
        sel = FWD_NONE;
        if (ex_write && !ex_load && ex_match && !ex_rd_zero) begin
            sel = FWD_EXMEM;
        end else if (wb_write && wb_match && !wb_rd_zero) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// mul_iter: W-bit iterative shift-add multiplier, one partial-product step
// per enabled clock.
//   clk, rst_n   clock and asynchronous active-low reset
//   start        load operands a/b, clear accumulator and step counter
//   step         perform one shift-add iteration
//   clear        drop all state (abort); wins over start/step
//   a, b         operands sampled on start
//   product      low W bits of the accumulated product
//   last         high during the step that completes the final iteration
module mul_iter
    import ex_stage_pkg::*;
#(
    parameter int W          = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         step,
    input  logic         clear,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] product,
    output logic         last
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [W-1:0]  acc;
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (clear) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

    assign product = acc;
    assign last    = step && (count == CW'(MUL_CYCLES - 1));

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 16-bit pipeline.
//   Inputs : ID/EX controls and operands (I*), MEM/WB write-back (WB*),
//            Stall (hold EX/MEM), Flush (replace instruction with bubble).
//   Outputs: ExBusy (hold ID/EX), registered EX/MEM fields (O*).
// Operand forwarding, ALU, BEQ resolution and the EX/MEM register live here;
// MUL is handed to mul_iter and sequenced by a small FSM.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | single-cycle ops flow through; MUL with write enable starts
// MUL   | multiplier iterating, ExBusy high, EX/MEM receives bubbles
// DONE  | product ready, captured on first non-stalled edge
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int W          = 16,
    parameter int MUL_CYCLES = 16   // must equal W
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         IRegWrite,
    input  logic         IALUSrc,
    input  logic         IBranch,
    input  logic         IMemWrite,
    input  logic         IMemRead,
    input  logic         IRegStore,
    input  logic [2:0]   IALUOP,
    input  logic [W-1:0] I1stArg,
    input  logic [W-1:0] I2ndArg,
    input  logic [W-1:0] I3rdArg,
    input  logic [W-1:0] IImm,
    input  logic [W-1:0] IRs1,
    input  logic [W-1:0] IRs2,
    input  logic [W-1:0] IRd,
    input  logic         WBRegWrite,
    input  logic [W-1:0] WBRd,
    input  logic [W-1:0] WBData,
    input  logic         Stall,
    input  logic         Flush,
    output logic         ExBusy,
    output logic         ORegWrite,
    output logic         OMemWrite,
    output logic         OMemRead,
    output logic         ORegStore,
    output logic [W-1:0] OALURes,
    output logic [W-1:0] OStoreData,
    output logic [W-1:0] ORd,
    output logic         OBranchTaken,
    output logic [W-1:0] OBranchTarget
);

    ex_state_t state;
    ex_state_t state_next;

    ctrl_t        in_ctrl;
    ctrl_t        out_ctrl;
    logic [W-1:0] alu_res_q;
    logic [W-1:0] store_q;
    logic [W-1:0] rd_q;
    logic         taken_q;
    logic [W-1:0] target_q;

    ctrl_t        ctrl_d;
    logic [W-1:0] alu_res_d;
    logic [W-1:0] store_d;
    logic [W-1:0] rd_d;
    logic         taken_d;
    logic [W-1:0] target_d;

    fwd_sel_t     sel_a;
    fwd_sel_t     sel_b;
    logic [W-1:0] op_a;
    logic [W-1:0] b_fwd;
    logic [W-1:0] op_b;
    logic [W-1:0] alu_res;
    logic         branch_taken;

    logic         mul_start;
    logic         mul_step;
    logic         mul_abort;
    logic         mul_last;
    logic [W-1:0] mul_product;

    ctrl_t        lat_ctrl;
    logic [W-1:0] lat_rd;
    logic [W-1:0] lat_store;

    always_comb begin
        in_ctrl           = CTRL_BUBBLE;
        in_ctrl.reg_write = IRegWrite;
        in_ctrl.mem_write = IMemWrite;
        in_ctrl.mem_read  = IMemRead;
        in_ctrl.reg_store = IRegStore;
    end

    // Forwarding
    always_comb begin
        sel_a = fwd_select(out_ctrl.reg_write, out_ctrl.mem_read, rd_q == IRs1,
                           rd_q == '0, WBRegWrite, WBRd == IRs1, WBRd == '0);
        sel_b = fwd_select(out_ctrl.reg_write, out_ctrl.mem_read, rd_q == IRs2,
                           rd_q == '0, WBRegWrite, WBRd == IRs2, WBRd == '0);

        case (sel_a)
            FWD_EXMEM: op_a = alu_res_q;
            FWD_WB:    op_a = WBData;
            default:   op_a = I1stArg;
        endcase

        case (sel_b)
            FWD_EXMEM: b_fwd = alu_res_q;
            FWD_WB:    b_fwd = WBData;
            default:   b_fwd = I2ndArg;
        endcase

        op_b = IALUSrc ? IImm : b_fwd;
    end

    // Single-cycle ALU; MUL goes through mul_iter, so its slot yields zero
    // here (only reachable for a MUL without a register write).
    always_comb begin
        alu_res = '0;
        case (IALUOP)
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_SLL: alu_res = op_a << op_b[3:0];
            ALU_SRL: alu_res = op_a >> op_b[3:0];
            default: alu_res = '0;
        endcase
        branch_taken = IBranch && (op_a == b_fwd);
    end

    // Multiplier sequencing
    assign mul_start = (state == IDLE) && (IALUOP == ALU_MUL) && IRegWrite && !Flush;
    assign mul_step  = (state == MUL);
    assign mul_abort = Flush && (state != IDLE);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ExBusy     = 1'b0;
        case (state)
            IDLE: begin
                if (mul_start) begin
                    ExBusy     = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                ExBusy = 1'b1;
                if (Flush) begin
                    state_next = IDLE;
                end else if (mul_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Flush aborts even while stalled.
                if (Flush || !Stall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    mul_iter #(
        .W          (W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul_iter (
        .clk     (CLK),
        .rst_n   (Reset),
        .start   (mul_start),
        .step    (mul_step),
        .clear   (mul_abort),
        .a       (op_a),
        .b       (op_b),
        .product (mul_product),
        .last    (mul_last)
    );

    // The MUL's destination and controls are kept here so DONE does not
    // depend on ID/EX still holding the instruction.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            lat_ctrl  <= CTRL_BUBBLE;
            lat_rd    <= '0;
            lat_store <= '0;
        end else if (mul_start) begin
            lat_ctrl  <= in_ctrl;
            lat_rd    <= IRd;
            lat_store <= b_fwd;
        end
    end

    // EX/MEM next value
    always_comb begin
        ctrl_d    = in_ctrl;
        alu_res_d = alu_res;
        store_d   = b_fwd;
        rd_d      = IRd;
        taken_d   = branch_taken;
        target_d  = I3rdArg;
        if (Flush || mul_start || (state == MUL)) begin
            ctrl_d    = CTRL_BUBBLE;
            alu_res_d = '0;
            store_d   = '0;
            rd_d      = '0;
            taken_d   = 1'b0;
            target_d  = '0;
        end else if (state == DONE) begin
            ctrl_d    = lat_ctrl;
            alu_res_d = mul_product;
            store_d   = lat_store;
            rd_d      = lat_rd;
            taken_d   = 1'b0;
            target_d  = '0;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            out_ctrl  <= CTRL_BUBBLE;
            alu_res_q <= '0;
            store_q   <= '0;
            rd_q      <= '0;
            taken_q   <= 1'b0;
            target_q  <= '0;
        end else if (!Stall) begin
            out_ctrl  <= ctrl_d;
            alu_res_q <= alu_res_d;
            store_q   <= store_d;
            rd_q      <= rd_d;
            taken_q   <= taken_d;
            target_q  <= target_d;
        end
    end

    assign ORegWrite     = out_ctrl.reg_write;
    assign OMemWrite     = out_ctrl.mem_write;
    assign OMemRead      = out_ctrl.mem_read;
    assign ORegStore     = out_ctrl.reg_store;
    assign OALURes       = alu_res_q;
    assign OStoreData    = store_q;
    assign ORd           = rd_q;
    assign OBranchTaken  = taken_q;
    assign OBranchTarget = target_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        CLK;
    logic        Reset;
    logic        IRegWrite, IALUSrc, IBranch, IMemWrite, IMemRead, IRegStore;
    logic [2:0]  IALUOP;
    logic [15:0] I1stArg, I2ndArg, I3rdArg, IImm, IRs1, IRs2, IRd;
    logic        WBRegWrite;
    logic [15:0] WBRd, WBData;
    logic        Stall, Flush;
    logic        ExBusy;
    logic        ORegWrite, OMemWrite, OMemRead, ORegStore;
    logic [15:0] OALURes, OStoreData, ORd;
    logic        OBranchTaken;
    logic [15:0] OBranchTarget;

    int checks   = 0;
    int failures = 0;

    ex_stage #(.W(16), .MUL_CYCLES(16)) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .IRegWrite     (IRegWrite),
        .IALUSrc       (IALUSrc),
        .IBranch       (IBranch),
        .IMemWrite     (IMemWrite),
        .IMemRead      (IMemRead),
        .IRegStore     (IRegStore),
        .IALUOP        (IALUOP),
        .I1stArg       (I1stArg),
        .I2ndArg       (I2ndArg),
        .I3rdArg       (I3rdArg),
        .IImm          (IImm),
        .IRs1          (IRs1),
        .IRs2          (IRs2),
        .IRd           (IRd),
        .WBRegWrite    (WBRegWrite),
        .WBRd          (WBRd),
        .WBData        (WBData),
        .Stall         (Stall),
        .Flush         (Flush),
        .ExBusy        (ExBusy),
        .ORegWrite     (ORegWrite),
        .OMemWrite     (OMemWrite),
        .OMemRead      (OMemRead),
        .ORegStore     (ORegStore),
        .OALURes       (OALURes),
        .OStoreData    (OStoreData),
        .ORd           (ORd),
        .OBranchTaken  (OBranchTaken),
        .OBranchTarget (OBranchTarget)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_bubble();
        IRegWrite = 0; IALUSrc = 0; IBranch = 0; IMemWrite = 0; IMemRead = 0; IRegStore = 0;
        IALUOP = ALU_ADD;
        I1stArg = 0; I2ndArg = 0; I3rdArg = 0; IImm = 0;
        IRs1 = 0; IRs2 = 0; IRd = 0;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [15:0] a1, input logic [15:0] a2,
                          input logic [15:0] imm, input logic src, input logic [15:0] rs1,
                          input logic [15:0] rs2, input logic [15:0] rd, input logic rw);
        set_bubble();
        IALUOP = op; I1stArg = a1; I2ndArg = a2; IImm = imm; IALUSrc = src;
        IRs1 = rs1; IRs2 = rs2; IRd = rd; IRegWrite = rw;
    endtask

    task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] rd,
                          input logic [15:0] exp, input bit stall_mul, input bit stall_done);
        int busy_cnt;
        int bubble_bad;
        busy_cnt   = 0;
        bubble_bad = 0;
        set_op(ALU_MUL, a, b, 16'h0, 1'b0, 16'h0, 16'h0, rd, 1'b1);
        #1;
        if (ExBusy) busy_cnt++;
        for (int e = 1; e <= 17; e++) begin
            tick();
            if (ORegWrite !== 1'b0) bubble_bad++;
            if (ExBusy) busy_cnt++;
            if (stall_mul && e == 3) Stall = 1;
            if (stall_mul && e == 6) Stall = 0;
        end
        chk("mul_bubbles", bubble_bad, 0);
        chk("mul_busy_cycles", busy_cnt, 17);
        chk("mul_done_not_busy", ExBusy, 0);
        if (stall_done) begin
            Stall = 1;
            for (int s = 0; s < 3; s++) begin
                tick();
                chk("mul_stall_hold_rw", ORegWrite, 0);
                chk("mul_stall_hold_busy", ExBusy, 0);
            end
            Stall = 0;
        end
        tick();
        chk("mul_result", OALURes, exp);
        chk("mul_rd", ORd, rd);
        chk("mul_rw", ORegWrite, 1);
        set_bubble();
    endtask

    int wrote;

    initial begin
        Reset = 0; Stall = 0; Flush = 0;
        WBRegWrite = 0; WBRd = 0; WBData = 0;
        set_bubble();
        tick();
        tick();
        chk("rst_alu", OALURes, 0);
        chk("rst_rw", ORegWrite, 0);
        chk("rst_busy", ExBusy, 0);
        chk("rst_taken", OBranchTaken, 0);
        Reset = 1;

        // ADD with immediate
        set_op(ALU_ADD, 16'h0003, 16'h0, 16'h0005, 1'b1, 16'd1, 16'd0, 16'd2, 1'b1);
        tick();
        chk("add_res", OALURes, 16'h0008);
        chk("add_rd", ORd, 2);
        chk("add_rw", ORegWrite, 1);

        // EX/MEM forwarding
        set_op(ALU_SUB, 16'h0010, 16'h0001, 16'h0, 1'b0, 16'd4, 16'd5, 16'd3, 1'b1);
        tick();
        chk("sub_res", OALURes, 16'h000F);
        set_op(ALU_XOR, 16'h0000, 16'h0, 16'h00FF, 1'b1, 16'd3, 16'd0, 16'd6, 1'b1);
        tick();
        chk("fwd_exmem", OALURes, 16'h00F0);

        // MEM/WB-only forwarding
        set_op(ALU_XOR, 16'h0000, 16'h0, 16'h00FF, 1'b1, 16'd7, 16'd0, 16'd8, 1'b1);
        WBRegWrite = 1; WBRd = 16'd7; WBData = 16'h000F;
        tick();
        chk("fwd_wb", OALURes, 16'h00F0);

        // both sources match: EX/MEM wins
        set_op(ALU_ADD, 16'h0000, 16'h0, 16'h0001, 1'b1, 16'd8, 16'd0, 16'd9, 1'b1);
        WBRd = 16'd8; WBData = 16'h1234;
        tick();
        chk("fwd_priority", OALURes, 16'h00F1);
        WBRegWrite = 0;

        // store: forwarded Rs2 as store data
        set_op(ALU_ADD, 16'h0100, 16'h0, 16'h0004, 1'b1, 16'd10, 16'd9, 16'd0, 1'b0);
        IMemWrite = 1;
        tick();
        chk("st_addr", OALURes, 16'h0104);
        chk("st_data", OStoreData, 16'h00F1);
        chk("st_mw", OMemWrite, 1);
        chk("st_rw", ORegWrite, 0);

        // logic and shifts
        set_op(ALU_AND, 16'hF0F0, 16'h0FF0, 16'h0, 1'b0, 16'd0, 16'd0, 16'd11, 1'b1);
        tick();
        chk("and_res", OALURes, 16'h00F0);
        set_op(ALU_OR, 16'hF0F0, 16'h0FF0, 16'h0, 1'b0, 16'd0, 16'd0, 16'd11, 1'b1);
        tick();
        chk("or_res", OALURes, 16'hFFF0);
        set_op(ALU_SLL, 16'h0001, 16'h0, 16'h0014, 1'b1, 16'd0, 16'd0, 16'd11, 1'b1);
        tick();
        chk("sll_res", OALURes, 16'h0010);
        set_op(ALU_SRL, 16'h8000, 16'h0, 16'h000F, 1'b1, 16'd0, 16'd0, 16'd11, 1'b1);
        tick();
        chk("srl_res", OALURes, 16'h0001);

        // BEQ
        set_op(ALU_SUB, 16'h00AA, 16'h00AA, 16'h0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
        IBranch = 1; I3rdArg = 16'h0040;
        tick();
        chk("beq_taken", OBranchTaken, 1);
        chk("beq_target", OBranchTarget, 16'h0040);
        I2ndArg = 16'h00AB;
        tick();
        chk("beq_not_taken", OBranchTaken, 0);
        IBranch = 0;

        // register 0 never forwarded
        set_op(ALU_ADD, 16'h5555, 16'h0, 16'h0, 1'b1, 16'd0, 16'd0, 16'd0, 1'b1);
        tick();
        chk("r0_write", OALURes, 16'h5555);
        set_op(ALU_ADD, 16'h0001, 16'h0, 16'h0001, 1'b1, 16'd0, 16'd0, 16'd13, 1'b1);
        WBRegWrite = 1; WBRd = 16'd0; WBData = 16'h7777;
        tick();
        chk("r0_no_fwd", OALURes, 16'h0002);
        WBRegWrite = 0;

        // a load in EX/MEM is not a forwarding source
        set_op(ALU_ADD, 16'h0200, 16'h0, 16'h0, 1'b1, 16'd0, 16'd0, 16'd12, 1'b1);
        IMemRead = 1;
        tick();
        chk("ld_mr", OMemRead, 1);
        set_op(ALU_ADD, 16'h0033, 16'h0, 16'h0, 1'b1, 16'd12, 16'd0, 16'd14, 1'b1);
        tick();
        chk("ld_no_fwd", OALURes, 16'h0033);

        // stall holds EX/MEM
        set_op(ALU_ADD, 16'h0001, 16'h0, 16'h0001, 1'b1, 16'd0, 16'd0, 16'd5, 1'b1);
        Stall = 1;
        tick();
        chk("stall_hold_res", OALURes, 16'h0033);
        chk("stall_hold_rd", ORd, 14);
        Stall = 0;
        tick();
        chk("stall_release", OALURes, 16'h0002);

        // flush of single-cycle op
        set_op(ALU_ADD, 16'h0007, 16'h0, 16'h0, 1'b1, 16'd0, 16'd0, 16'd6, 1'b1);
        Flush = 1;
        tick();
        chk("flush_rw", ORegWrite, 0);
        chk("flush_res", OALURes, 0);
        Flush = 0;

        set_op(ALU_ADD, 16'h0009, 16'h0, 16'h0, 1'b1, 16'd0, 16'd0, 16'd7, 1'b1);
        tick();
        chk("pre_mul", OALURes, 16'h0009);

        do_mul(16'h0123, 16'h0011, 16'd13, 16'h1353, 1'b0, 1'b0);
        do_mul(16'h0123, 16'h0011, 16'd14, 16'h1353, 1'b1, 1'b1);
        do_mul(16'h00FF, 16'h0101, 16'd15, 16'hFFFF, 1'b0, 1'b0);

        // flush during MUL drops the product
        set_op(ALU_MUL, 16'h0003, 16'h0004, 16'h0, 1'b0, 16'd0, 16'd0, 16'd9, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        Flush = 1;
        tick();
        Flush = 0;
        set_bubble();
        #1;
        chk("mul_flush_busy", ExBusy, 0);
        wrote = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ORegWrite !== 1'b0) wrote++;
        end
        chk("mul_flush_no_write", wrote, 0);

        // reset in the middle of a MUL (count 7) with EX/MEM held by Stall
        set_op(ALU_ADD, 16'h0021, 16'h0, 16'h0, 1'b1, 16'd0, 16'd0, 16'd4, 1'b1);
        tick();
        chk("pre_rst_add", OALURes, 16'h0021);
        Stall = 1;
        set_op(ALU_MUL, 16'h0005, 16'h0006, 16'h0, 1'b0, 16'd0, 16'd0, 16'd9, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        chk("mid_mul_hold", OALURes, 16'h0021);
        chk("mid_mul_busy", ExBusy, 1);
        #2;
        Reset = 0;
        Stall = 0;
        set_bubble();
        #1;
        chk("rst_mid_res", OALURes, 0);
        chk("rst_mid_rd", ORd, 0);
        chk("rst_mid_rw", ORegWrite, 0);
        chk("rst_mid_busy", ExBusy, 0);
        tick();
        Reset = 1;
        set_op(ALU_ADD, 16'h0002, 16'h0, 16'h0003, 1'b1, 16'd0, 16'd0, 16'd3, 1'b1);
        #1;
        chk("post_rst_busy", ExBusy, 0);
        tick();
        chk("post_rst_add", OALURes, 16'h0005);
        chk("post_rst_rw", ORegWrite, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-bit pipeline; sits directly downstream of the ID/EX register and consumes its outputs.
- Contains operand forwarding, an 8-op ALU, an iterative 16-cycle multiplier FSM, BEQ branch resolution, and the EX/MEM output register.
- Supports stall (from MEM), flush, and a busy back-pressure signal to hold ID/EX.

Parameters:
- W, 16, datapath and register-field width.
- MUL_CYCLES, 16, multiplier iteration count; must equal W.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IRegWrite, IALUSrc, IBranch, IMemWrite, IMemRead, IRegStore  in  1 each  control from ID/EX.
- IALUOP  in  3  ALU opcode.
- I1stArg  in  W  Rs1 value.
- I2ndArg  in  W  Rs2 value.
- I3rdArg  in  W  branch target.
- IImm  in  W  immediate.
- IRs1, IRs2, IRd  in  W  register numbers.
- WBRegWrite  in  1  MEM/WB write enable.
- WBRd  in  W  MEM/WB destination.
- WBData  in  W  MEM/WB write data.
- Stall  in  1  MEM not ready; hold EX/MEM.
- Flush  in  1  replace current instruction with bubble.
- ExBusy  out  1  hold ID/EX this cycle.
- ORegWrite, OMemWrite, OMemRead, ORegStore  out  1 each  registered control.
- OALURes  out  W  registered ALU result / address.
- OStoreData  out  W  registered forwarded Rs2.
- ORd  out  W  registered destination.
- OBranchTaken  out  1  registered branch decision.
- OBranchTarget  out  W  registered target.

Behaviour:
- Reset low (async): all outputs 0, FSM in IDLE, multiplier registers 0.
- Forwarding, for A from IRs1 and Bfwd from IRs2:
  - EX/MEM has priority: use OALURes if ORegWrite=1, OMemRead=0, ORd==Rsx, ORd!=0.
  - Otherwise MEM/WB: use WBData if WBRegWrite=1, WBRd==Rsx, WBRd!=0.
  - Otherwise the ID/EX argument.
  - Register 0 is never forwarded.
  - Load-use hazards are resolved upstream.
- B = IALUSrc ? IImm : Bfwd.
- ALUOP encoding (mod 2^W, no flags):
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
  - 101 SLL and 110 SRL, shift amount B[3:0].
  - 111 MUL, low W bits of the product.
- Branch: taken = IBranch & (A==Bfwd); target = I3rdArg. Registered with the rest of EX/MEM.
- Single-cycle ops, latency 1 edge.
  - On each edge with Stall=0 and FSM IDLE: EX/MEM loads the result.
  - The result is: controls, ALU result, OStoreData=Bfwd, ORd=IRd, branch fields.
- Multiplier FSM (states IDLE, MUL, DONE):
  - IDLE: when IALUOP==111 and IRegWrite=1 and Flush=0:
    - ExBusy=1 (combinational).
    - A and B are latched, counter=0.
    - Next state MUL.
    - EX/MEM loads a bubble (all controls 0) if Stall=0.
  - MUL: ExBusy=1; one shift-add step per edge.
    - After MUL_CYCLES steps, next state DONE.
    - EX/MEM loads a bubble each non-stalled edge.
  - DONE: ExBusy=0; product is presented.
    - On the first edge with Stall=0, EX/MEM captures the product plus the latched IRd and controls; FSM goes to IDLE.
    - If Stall=1, remain in DONE.
  - MUL result is in EX/MEM after the 18th rising edge following entry, with no stalls.
- Stall=1: EX/MEM holds all values. The multiplier keeps iterating in MUL.
- Flush=1: EX/MEM loads a bubble on a non-stalled edge. A flush in MUL or DONE aborts to IDLE and drops the product. Flush has priority over Stall for FSM abort only.
- Simultaneous events: a WB write and an EX/MEM match to the same register resolve by EX/MEM priority.
- A bubble input (all controls 0) produces ORegWrite=OMemWrite=OMemRead=OBranchTaken=0.

Decomposition:
- Shared package:
  - ALUOP encodings (ALU_ADD..ALU_MUL).
  - FSM state typedef (IDLE/MUL/DONE).
  - Bubble control constant.
  - Forward-select enum (FWD_NONE/FWD_EXMEM/FWD_WB).
- One sub-module, mul_iter: a W-bit iterative shift-add multiplier with start/done, holding the counter and partial product.
- Forwarding, ALU and the EX/MEM register stay in ex_stage.

Test Plan:
1. Reset low mid-MUL (state MUL, count 7) -> all outputs 0, ExBusy=0, FSM IDLE on the next cycle.
2. ADD, I1stArg=0x0003, IALUSrc=1, IImm=0x0005, IRd=2, IRegWrite=1 -> after 1 edge OALURes=0x0008, ORd=2, ORegWrite=1.
3. Back-to-back forwarding:
   - Instruction 1: SUB r3 = 0x0010 − 0x0001.
   - Instruction 2: IRs1=3, stale I1stArg=0x0000, XOR with 0x00FF.
   - Required: OALURes=0x00F0. The same test with WB-only match uses WBData.
4. MUL 0x0123×0x0011, Stall=0:
   - ExBusy=1 for 17 cycles.
   - Bubbles in EX/MEM meanwhile.
   - OALURes=0x1353 after the 18th edge.
   - Repeat with Stall=1 held 3 cycles in DONE: capture is delayed 3 cycles, value unchanged.
5. BEQ, IBranch=1, A=B=0x00AA, I3rdArg=0x0040 -> OBranchTaken=1, OBranchTarget=0x0040. With A≠B -> OBranchTaken=0.
6. Forwarding edge cases and flush:
   - Forwarding to IRs1=0 with ORd=0, ORegWrite=1 -> no forwarding.
   - Flush during MUL -> FSM IDLE, ExBusy=0 next cycle, no product written.
